// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: shared pixel type, window FSM states and counter sizing for the sliding-window generator.
package conv_pkg;
  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} win_state_e;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_window_gen_rowbuf.sv
// rowbuf: unreset COL-deep pixel delay line advanced only on enable.
module rowbuf
  import conv_pkg::*;
#(
  parameter int COL       = 5,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] din,
  output logic [BIT_WIDTH-1:0] dout
);
  logic [BIT_WIDTH-1:0] mem [COL];
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < COL; i++) mem[i] <= mem[i-1];
    end
  end
  assign dout = mem[COL-1];
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: KxK sliding-window generator over a raster pixel stream, flagging fully-inside windows.
// Optional start-of-frame input enabled by defining CONV_WIN_SOF_EN.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W     = 5,
  parameter int IMG_H     = 5,
  parameter int K         = 3,
  parameter int BIT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [BIT_WIDTH-1:0]       in_data,
`ifdef CONV_WIN_SOF_EN
  input  logic                       in_sof,
`endif
  output logic                       out_valid,
  output logic [K*K*BIT_WIDTH-1:0]   out_win,
  output logic                       frame_done
);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W-1);
  localparam logic [CW-1:0] C_K    = CW'(K-1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H-1);
  localparam logic [RW-1:0] R_K    = RW'(K-1);
  logic [CW-1:0] col, col_e, col_nx;
  logic [RW-1:0] row, row_e, row_nx;
  logic sof, last, first, full;
  win_state_e state, state_nx;
  logic [BIT_WIDTH-1:0] tap [K-1];
  logic [BIT_WIDTH-1:0] cvec [K];
  logic [BIT_WIDTH-1:0] win [K][K];
`ifdef CONV_WIN_SOF_EN
  assign sof = in_valid & in_sof;
`else
  assign sof = 1'b0;
`endif
  genvar g;
  generate
    for (g = 0; g < K-1; g++) begin : g_rb
      rowbuf #(.COL(IMG_W), .BIT_WIDTH(BIT_WIDTH)) u_rb (
        .clk  (clk),
        .en   (in_valid),
        .din  (g == 0 ? in_data : tap[g == 0 ? 0 : g-1]),
        .dout (tap[g])
      );
    end
  endgenerate
  // Row K-1 is the live pixel; deeper delay stages feed progressively older rows.
  always_comb begin
    cvec[K-1] = in_data;
    for (int r = 0; r < K-1; r++) cvec[r] = tap[K-2-r];
  end
  always_comb begin
    col_e    = sof ? '0 : col;
    row_e    = sof ? '0 : row;
    last     = (row_e == R_LAST) && (col_e == C_LAST);
    first    = (row_e == R_K) && (col_e == C_K);
    full     = (row_e >= R_K) && (col_e >= C_K);
    col_nx   = (col_e == C_LAST) ? '0 : col_e + 1'b1;
    row_nx   = (col_e != C_LAST) ? row_e : (row_e == R_LAST) ? '0 : row_e + 1'b1;
    state_nx = (sof || last) ? FILL : first ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      state      <= FILL;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else begin
      out_valid  <= in_valid & full;
      frame_done <= in_valid & last;
      if (in_valid) begin
        col   <= col_nx;
        row   <= row_nx;
        state <= state_nx;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) win[r][c] <= win[r][c+1];
          win[r][K-1] <= cvec[r];
        end
      end
    end
  end
  always_comb begin
    out_win = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) out_win[(r*K+c)*BIT_WIDTH +: BIT_WIDTH] = win[r][c];
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized self-checking bench comparing every accept against an image-array window model.
module tb_conv_window_gen;
  localparam int W = 5, H = 5, K = 3, BW = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, in_sof = 0;
  logic [BW-1:0] in_data = '0;
  logic out_valid, frame_done;
  logic [K*K*BW-1:0] out_win;
  int checks = 0, errors = 0;
  int img [H][W];
  int mr = 0, mc = 0, nwin = 0, ndone = 0;
  logic [K*K*BW-1:0] first_win, last_win;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .K(K), .BIT_WIDTH(BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
`ifdef CONV_WIN_SOF_EN
    .in_sof     (in_sof),
`endif
    .out_valid  (out_valid),
    .out_win    (out_win),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [K*K*BW-1:0] const_win(input int base);
    logic [K*K*BW-1:0] v;
    v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) v[(r*K+c)*BW +: BW] = BW'(base + r*W + c);
    return v;
  endfunction

  task automatic send(input int d, input logic sof);
    logic ev, ed;
    logic [K*K*BW-1:0] e;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = d;
    ev = (mr >= K-1) && (mc >= K-1);
    ed = (mr == H-1) && (mc == W-1);
    e = '0;
    if (ev)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) e[(r*K+c)*BW +: BW] = BW'(img[mr-K+1+r][mc-K+1+c]);
    mc++;
    if (mc == W) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
    in_valid = 1; in_data = BW'(d); in_sof = sof;
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0;
    checks++;
    if (out_valid !== ev) begin errors++; $display("FAIL valid got %b want %b (pix %0d)", out_valid, ev, d); end
    checks++;
    if (frame_done !== ed) begin errors++; $display("FAIL frame_done got %b want %b (pix %0d)", frame_done, ed, d); end
    if (ev) begin
      checks++;
      if (out_win !== e) begin errors++; $display("FAIL window got %h want %h (pix %0d)", out_win, e, d); end
    end
    if (out_valid === 1'b1) begin
      if (nwin == 0) first_win = out_win;
      nwin++;
    end
    if (frame_done === 1'b1) begin ndone++; last_win = out_win; end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 0; in_data = BW'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL gap outputs got %b%b want 00", out_valid, frame_done);
      end
    end
  endtask

  task automatic frame(input int base, input int maxgap);
    for (int p = 0; p < W*H; p++) begin
      send(base + p, 1'b0);
      if (maxgap > 0) gap($urandom_range(0, maxgap));
    end
  endtask

  task automatic do_reset();
    in_valid = 0; rst_n = 0;
    #3;
    checks++;
    if (out_valid !== 0 || frame_done !== 0 || out_win !== '0) begin
      errors++; $display("FAIL reset got v=%b d=%b win=%h want 0 0 0", out_valid, frame_done, out_win);
    end
    @(posedge clk); #1; rst_n = 1;
    mr = 0; mc = 0;
  endtask

  task automatic test_reset(); do_reset(); endtask

  task automatic test_basic();
    nwin = 0; ndone = 0;
    frame(0, 0);
    checks++;
    if (nwin != 9) begin errors++; $display("FAIL basic_count got %0d want 9", nwin); end
    checks++;
    if (first_win !== const_win(0)) begin errors++; $display("FAIL basic_first got %h want %h", first_win, const_win(0)); end
    checks++;
    if (ndone != 1 || last_win !== const_win(12)) begin
      errors++; $display("FAIL basic_last got %0d/%h want 1/%h", ndone, last_win, const_win(12));
    end
  endtask

  task automatic test_gaps();
    nwin = 0;
    for (int p = 0; p < W*H; p++) begin
      send(p, 1'b0);
      gap((p % 2 == 0) ? 1 : $urandom_range(0, 4));
    end
    checks++;
    if (nwin != 9) begin errors++; $display("FAIL gaps_count got %0d want 9", nwin); end
  endtask

  task automatic test_back_to_back();
    frame(0, 0);
    nwin = 0; ndone = 0;
    frame(100, 0);
    checks++;
    if (first_win !== const_win(100)) begin errors++; $display("FAIL b2b_first got %h want %h", first_win, const_win(100)); end
    checks++;
    if (nwin != 9 || ndone != 1) begin errors++; $display("FAIL b2b_count got %0d/%0d want 9/1", nwin, ndone); end
  endtask

  task automatic test_mid_reset();
    for (int p = 0; p <= 17; p++) send(p, 1'b0);
    do_reset();
    nwin = 0;
    for (int p = 0; p < W*H; p++) send(50 + p, 1'b0);
    checks++;
    if (nwin != 9 || first_win !== const_win(50)) begin
      errors++; $display("FAIL mid_reset got %0d/%h want 9/%h", nwin, first_win, const_win(50));
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      nwin = 0; ndone = 0;
      for (int p = 0; p < W*H; p++) begin
        send(int'($urandom_range(0, 255)), 1'b0);
        if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
      end
      checks++;
      if (nwin != 9 || ndone != 1) begin errors++; $display("FAIL random_count got %0d/%0d want 9/1", nwin, ndone); end
    end
  endtask

`ifdef CONV_WIN_SOF_EN
  task automatic test_sof();
    nwin = 0; ndone = 0;
    for (int p = 0; p < 8; p++) send(p, 1'b0);
    send(8, 1'b1);
    for (int p = 1; p < W*H; p++) send(8 + p, 1'b0);
    checks++;
    if (nwin != 9 || ndone != 1 || first_win !== const_win(8)) begin
      errors++; $display("FAIL sof got %0d/%0d/%h want 9/1/%h", nwin, ndone, first_win, const_win(8));
    end
    send(7, 1'b0);
    gap(1);
    in_sof = 1; @(posedge clk); #1; in_sof = 0;
    for (int p = 1; p < W*H; p++) send(200 + p, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef CONV_WIN_SOF_EN
    do_reset();
    test_sof();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator for the convolution datapath. It consumes a raster-order pixel stream and chains K-1 row delay lines. It registers a K×K window and flags each window that lies fully inside the image. It sits directly downstream of the pixel input and directly upstream of the MAC array, which consumes one window per `out_valid`.

## Interface
- `IMG_W`, default 5: image width in pixels; row delay length; ≥ K
- `IMG_H`, default 5: image height in rows; ≥ K
- `K`, default 3: window size; ≥ 2
- `BIT_WIDTH`, default 8: pixel width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  pixel accept strobe; sole advance condition
- `in_data`  in  BIT_WIDTH  pixel, raster order
- `in_sof`  in  1  start-of-frame; present only with `CONV_WIN_SOF_EN`
- `out_valid`  out  1  window valid, single-cycle per window
- `out_win`  out  K*K*BIT_WIDTH  window; element (r,c) at `[(r*K+c)*BIT_WIDTH +: BIT_WIDTH]`; r=0 oldest row, c=0 leftmost column
- `frame_done`  out  1  pulses with the last window of a frame

## Operation
- Delay chain: K-1 `rowbuf` instances (COL=IMG_W), all enabled by `in_valid`. Stage 0 takes `in_data`; stage i takes the output of stage i-1.
- Column vector on accept: row K-1 = `in_data`, row K-2 = stage 0 out, …, row 0 = stage K-2 out.
- Window regs: on accept, each row shifts left (c ← c+1) and the column vector enters at c=K-1. No change when `in_valid`=0.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) index the accepted pixel. `col` wraps to 0 and increments `row`. `row` wraps to 0 after (IMG_H-1, IMG_W-1).
- Window valid when accepted pixel has `row ≥ K-1` and `col ≥ K-1`. This gives exactly (IMG_H-K+1)*(IMG_W-K+1) windows per frame. Windows straddling a row boundary are never flagged.
- FSM `FILL` → `RUN`:
  - `FILL` → `RUN` when the pixel at (K-1, K-1) is accepted.
  - `RUN` → `FILL` on acceptance of (IMG_H-1, IMG_W-1).
  - `out_valid` is qualified by the counters in both states. The state is exposed for debug and coverage only.
- Delay lines have no reset. Stale or undefined contents are masked solely by the counter qualification. There is no flush between frames.
- Back-to-back frames: the first pixel of the next frame may follow the last pixel with no gap.

## Timing
- Reset values: `out_valid`=0, `frame_done`=0, `out_win`=all zero, `col`=`row`=0, state `FILL`. Reset mid-frame discards the partial frame. The next accepted pixel is (0,0).
- Latency: `out_valid`/`out_win` register one cycle after the accepting `clk` edge of the completing pixel.
- `out_valid` and `frame_done` are high for exactly one cycle per event. They are 0 in any cycle following a non-accept.
- `in_valid` gaps of any length preserve all state. The window is held until the next accept.
- `frame_done` coincides with `out_valid` of window (IMG_H-K, IMG_W-K).

## Configuration
- `CONV_WIN_SOF_EN` defined:
  - Adds `in_sof`. When `in_sof`=1 with `in_valid`=1, that pixel is treated as (0,0): counters are forced, state goes to `FILL`, and there is no `frame_done` for the aborted frame.
  - `in_sof` without `in_valid` is ignored.
- Undefined: the port is absent and counters free-run on pixel count alone.

## Structure
- `conv_pkg`: `pixel_t` typedef (`logic [BIT_WIDTH-1:0]`), state enum `win_state_e {FILL, RUN}`, counter width helper via `$clog2`.
- Sub-module: `rowbuf`, instantiated K-1 times in a generate loop. All counters, the FSM and window regs live in `conv_window_gen`.

## Test plan
- K=3, 5×5, pixel = raster index 0..24, continuous `in_valid` → first `out_valid` one cycle after pixel 12 is accepted, window {0,1,2,5,6,7,10,11,12}. 9 windows total; last window {12,13,14,17,18,19,22,23,24} with `frame_done`.
- Same frame with `in_valid` toggling 1/0 and random gaps → identical 9 windows in order. No `out_valid` in gap cycles.
- Two frames back-to-back, second frame = index+100 → second frame's first window {100,101,102,105,106,107,110,111,112}. No window is flagged from pixels 3–4 or 8–9 of any row.
- Assert `rst_n`=0 after pixel 17, then send a fresh frame → `out_valid`=0 until fresh pixel 12. Windows match a clean frame.
- `CONV_WIN_SOF_EN`: `in_sof` with pixel 8 of frame 1, then a full frame from there → no `frame_done` for frame 1. The new frame yields exactly 9 correct windows.
- Port check with the macro undefined → `in_sof` is absent. Behaviour matches the first scenario.
